// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
// Holds the RV32I funct3 size encodings, the FSM state type, the default
// data memory size and the size/alignment legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int LSU_MEM_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_DONE
  } lsu_state_e;

  // Illegal funct3 or misaligned access; the range check lives in the top.
  // Stores have no unsigned variants, so BU/HU are illegal for stores.
  function automatic logic lsu_format_err(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = lo[0];
      F3_W:    err = (lo != 2'b00);
      F3_BU:   err = is_store;
      F3_HU:   err = is_store | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extraction and store lane merge
// Ports:
//   funct3     access size/sign encoding
//   lane       byte address bits [1:0]
//   rdata      word read from memory
//   wdata      right-aligned store data
//   load_data  selected lane, sign- or zero-extended
//   store_word rdata with the addressed lane replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'h00;
    case (lane)
      2'd0: rd_byte = rdata[7:0];
      2'd1: rd_byte = rdata[15:8];
      2'd2: rd_byte = rdata[23:16];
      2'd3: rd_byte = rdata[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'h000000, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'h0000, rd_half};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = rdata;
        case (lane)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = rdata;
        endcase
      end
      F3_H: begin
        store_word = rdata;
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with read-modify-write stores
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_is_store, req_funct3        access kind and size
//   req_addr, req_wdata             byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle response
//   Mem_Read, Mem_Write, M_a        word memory strobes and aligned address
//   Mem_WriteData, Mem_ReadData     memory write word / combinational read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] M_a,
  output logic [31:0]       Mem_WriteData,
  input  logic [31:0]       Mem_ReadData
);

  lsu_state_e  state;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic [ADDR_W-1:0] word_addr;
  logic              range_err;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign range_err = (word_addr + ADDR_W'(3)) >= ADDR_W'(MEM_BYTES);
  assign req_err   = range_err | lsu_format_err(req_is_store, req_funct3, req_addr[1:0]);

  // Operates on the latched request; Mem_ReadData is only meaningful while
  // Mem_Read is high, which is exactly when LOAD/RMW_RD consume these results.
  lsu_align u_align (
    .funct3     (funct3_q),
    .lane       (lane_q),
    .rdata      (Mem_ReadData),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Every output is registered and set on the edge that enters the state
  // it belongs to, so strobes line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      rsp_err       <= 1'b0;
      Mem_Read      <= 1'b0;
      Mem_Write     <= 1'b0;
      M_a           <= '0;
      Mem_WriteData <= 32'h0;
      lane_q        <= 2'b00;
      funct3_q      <= 3'b000;
      wdata_q       <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      Mem_Read  <= 1'b0;
      Mem_Write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lane_q    <= req_addr[1:0];
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (!req_is_store) begin
              state    <= S_LOAD;
              Mem_Read <= 1'b1;
              M_a      <= word_addr;
            end else if (req_funct3 == F3_W) begin
              state         <= S_WRITE;
              Mem_Write     <= 1'b1;
              M_a           <= word_addr;
              Mem_WriteData <= req_wdata;
            end else begin
              state    <= S_RMW_RD;
              Mem_Read <= 1'b1;
              M_a      <= word_addr;
            end
          end
        end
        S_LOAD: begin
          state     <= S_DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_data;
        end
        S_RMW_RD: begin
          state         <= S_WRITE;
          Mem_Write     <= 1'b1;
          Mem_WriteData <= store_word;
        end
        S_WRITE: begin
          state     <= S_DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store unit between the core's execute stage and the word-wide data memory.
- Accepts one byte, halfword or word load/store per request over a valid/ready handshake.
- Drives word-aligned memory reads and writes. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data, or an error flag for misaligned, illegal or out-of-range accesses.

Parameters:
MEM_BYTES, 16, data memory size in bytes. An access faults if (word-aligned address + 3) >= MEM_BYTES.
ADDR_W, 32, address width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access error, qualified by rsp_valid
Mem_Read  out  1  memory read strobe
Mem_Write  out  1  memory write strobe
M_a  out  ADDR_W  word-aligned memory address, bits [1:0] = 0
Mem_WriteData  out  32  write word
Mem_ReadData  in  32  read word, combinational, valid in the same cycle as Mem_Read

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; Mem_Read=0; Mem_Write=0; M_a=0; Mem_WriteData=0.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid && req_ready. At acceptance, addr, funct3, is_store and wdata are latched.
- Error check at acceptance. An error is any of:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - illegal funct3 (load 3/6/7; store >=3)
  - range fault
- Errored request: go to DONE. No memory strobe is ever asserted. In DONE, rsp_err=1 and rsp_rdata=0.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
  - IDLE -> LOAD for a legal load.
  - IDLE -> WRITE for a legal SW.
  - IDLE -> RMW_RD for a legal SB/SH.
  - LOAD: Mem_Read=1, M_a={addr[31:2],2'b00}. Select the byte/half by addr[1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU. Register the result. -> DONE.
  - RMW_RD: Mem_Read=1. Register Mem_ReadData. -> WRITE.
  - WRITE: Mem_Write=1, same M_a.
    - SW: Mem_WriteData = wdata.
    - SB/SH: Mem_WriteData = captured word with lane addr[1:0] (byte) or addr[1] (half) replaced by the low bits of wdata.
    - -> DONE.
  - DONE: rsp_valid=1 for exactly one cycle. -> IDLE.
- Latency from acceptance to rsp_valid, counted in cycles after the accept edge:
  - load: 2
  - SW: 2
  - SB/SH: 3
  - error: 1
- A new request may be accepted in the cycle after DONE, when the unit is back in IDLE.
- Mem_Read and Mem_Write are never high together, and each is high for exactly one cycle per access.
- Reset asserted in any state returns the FSM to IDLE at the next edge. The in-flight request is dropped with no response. Any write not yet issued is never issued.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding
  - MEM_BYTES default
- One natural sub-module: lsu_align. It is purely combinational and performs load-lane extraction with sign/zero extension plus store-lane merge. It is reused by the FSM for LOAD and WRITE.

Test Plan:
Memory preloaded as follows: bytes 0-3 = 02 00 00 00; bytes 4-7 = 04 00 00 00; bytes 8-11 = 08 00 00 00; bytes 12-15 = C0 D0 E0 F0.
- LW addr 12 -> rsp_valid 2 cycles after accept; rsp_rdata=0xF0E0D0C0; rsp_err=0; one Mem_Read pulse with M_a=12.
- LB addr 13 -> 0xFFFFFFD0; LBU addr 13 -> 0x000000D0; LH addr 14 -> 0xFFFFF0E0; LHU addr 14 -> 0x0000F0E0.
- SB addr 5 wdata 0x123456AB -> Mem_Read at M_a=4, then Mem_Write with Mem_WriteData=0x0000AB04, rsp 3 cycles after accept; a following LW addr 4 -> 0x0000AB04.
- LW addr 2, SH addr 9, LW addr 16 (range) and load funct3=3 -> each gives rsp_err=1, rsp_rdata=0, rsp 1 cycle after accept; zero memory strobes.
- SH addr 8 wdata 0xBEEF with reset pulsed during RMW_RD -> no Mem_Write; no rsp_valid; req_ready=1 after reset; LW addr 8 -> 0x00000008.
- Back-to-back: req_valid held high for SW addr 0 wdata 0xCAFEBABE then LW addr 0 -> the second request is accepted only after DONE; LW returns 0xCAFEBABE.
